// File: rtl/arbiter_in_pkg.sv
// Shared state encodings, direction indices and rotation order for the router's input/output arbiters.
// Also holds the arbitration helpers used by arbiter_in (checker build: ARBITER_IN_CHECKERS_EN).
package arbiter_in_pkg;

  typedef enum logic [5:0] {
    ST_IDLE = 6'b000001,
    ST_N    = 6'b000010,
    ST_E    = 6'b000100,
    ST_W    = 6'b001000,
    ST_S    = 6'b010000,
    ST_L    = 6'b100000
  } state_e;

  typedef enum logic [2:0] {
    DIR_N = 3'd0,
    DIR_E = 3'd1,
    DIR_W = 3'd2,
    DIR_S = 3'd3,
    DIR_L = 3'd4
  } dir_e;

  localparam int NUM_DIRS = 5;

  // Successor of each direction in the rotation N->E->W->S->L->N.
  localparam dir_e ROT_NEXT [0:NUM_DIRS-1] = '{DIR_E, DIR_W, DIR_S, DIR_L, DIR_N};

  function automatic logic [5:0] dir_code(input dir_e d);
    return 6'b000010 << d;
  endfunction

  // First asserted request scanning the rotation from 'start'; IDLE when nothing is requested.
  function automatic logic [5:0] arbitrate(input logic [4:0] req, input dir_e start);
    logic [5:0] res;
    dir_e       idx;
    logic       found;
    res   = ST_IDLE;
    idx   = start;
    found = 1'b0;
    for (int k = 0; k < NUM_DIRS; k++) begin
      if (!found && req[idx]) begin
        res   = dir_code(idx);
        found = 1'b1;
      end
      idx = ROT_NEXT[idx];
    end
    return res;
  endfunction

  function automatic logic is_onehot6(input logic [5:0] s);
    return (s != 6'd0) && ((s & (s - 6'd1)) == 6'd0);
  endfunction

  function automatic logic multi_hot5(input logic [4:0] v);
    return (v & (v - 5'd1)) != 5'd0;
  endfunction

endpackage

// File: rtl/arbiter_in_checkers.sv
// Sticky error flag for arbiter_in: raised when the state is not one-hot or several X_* fire together.
// Only instantiated when ARBITER_IN_CHECKERS_EN is defined.
module arbiter_in_checkers
  import arbiter_in_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] state_i,
  input  logic [4:0] x_i,
  output logic       err_state_o
);

  logic err_q;
  logic err_d;

  always_comb begin
    err_d = err_q;
    if (!is_onehot6(state_i) || multi_hot5(x_i)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_state_o = err_q;

endmodule

// File: rtl/arbiter_in.sv
// Input-side arbiter for one router input port: sticky, rotating-priority one-hot FSM over N/E/W/S/L.
// Define ARBITER_IN_CHECKERS_EN to add the registered err_state checker output.
module arbiter_in
  import arbiter_in_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_X_N,
  input  logic req_X_E,
  input  logic req_X_W,
  input  logic req_X_S,
  input  logic req_X_L,
  output logic X_N,
  output logic X_E,
  output logic X_W,
  output logic X_S,
  output logic X_L
`ifdef ARBITER_IN_CHECKERS_EN
  ,
  output logic err_state
`endif
);

  logic [5:0] state_q;
  logic [5:0] state_d;
  logic [4:0] reqVec;
  logic [4:0] xVec;
  dir_e       curDir;
  logic       inDir;

  assign reqVec = {req_X_L, req_X_S, req_X_W, req_X_E, req_X_N};

  // Only exact direction codes count as "holding" a direction; IDLE and corrupt codes both
  // fall back to fixed N-first priority with all outputs low.
  always_comb begin
    state_d = state_q;
    xVec    = '0;
    curDir  = DIR_N;
    inDir   = 1'b1;
    case (state_q)
      ST_N:    curDir = DIR_N;
      ST_E:    curDir = DIR_E;
      ST_W:    curDir = DIR_W;
      ST_S:    curDir = DIR_S;
      ST_L:    curDir = DIR_L;
      default: inDir  = 1'b0;
    endcase
    if (inDir) begin
      xVec[curDir] = reqVec[curDir];
      if (!reqVec[curDir]) begin
        state_d = arbitrate(reqVec, ROT_NEXT[curDir]);
      end
    end else begin
      state_d = arbitrate(reqVec, DIR_N);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign X_N = xVec[DIR_N];
  assign X_E = xVec[DIR_E];
  assign X_W = xVec[DIR_W];
  assign X_S = xVec[DIR_S];
  assign X_L = xVec[DIR_L];

`ifdef ARBITER_IN_CHECKERS_EN
  arbiter_in_checkers u_checkers (
    .clk         (clk),
    .reset       (reset),
    .state_i     (state_q),
    .x_i         (xVec),
    .err_state_o (err_state)
  );
`endif

endmodule
